dram_pair_arbiter: RTL and testbench

//  Shares the single TX_RD/RX_RD cache-line channel between NUM_REQ requesters that each issue paired (k,l) BWT reads.

---
 rtl/afu_pkg.sv | 26 ++
 rtl/dram_pair_arbiter_tag_fifo.sv | 58 +++++
 rtl/dram_pair_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dram_pair_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afu_pkg.sv
// Shared AFU constants, arbiter FSM encoding and a constant-evaluable clog2.
package afu_pkg;

   localparam int CL_W   = 512;
   localparam int ADDR_W = 58;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE_K = 2'd1,
      ST_ISSUE_L = 2'd2
   } arb_state_t;

   // Ceiling log2, usable in parameter expressions.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dram_pair_arbiter_tag_fifo.sv
// In-order requester-ID FIFO; push and pop may coincide even when full.
module tag_fifo
   import afu_pkg::*;
#(
   parameter  int WIDTH = 2,
   parameter  int DEPTH = 8,
   localparam int PTR_W = clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   // A pop in the same cycle frees the slot the push is about to use.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage write; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dram_pair_arbiter.sv
// Round-robin arbiter issuing paired (k,l) line reads and joining the responses.
module dram_pair_arbiter
   import afu_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int ID_W      = 2,
   parameter  int MAX_OUTST = 8,
   localparam int CNT_W     = clog2(MAX_OUTST) + 1
) (
   input  logic                      CLK_400M,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_k,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_l,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      spl_tx_rd_almostfull,
   output logic                      cor_tx_rd_valid,
   output logic [ADDR_W-1:0]         cor_tx_rd_addr,
   input  logic                      io_rx_rd_valid,
   input  logic [CL_W-1:0]           io_rx_data,
   output logic                      resp_valid,
   output logic [ID_W-1:0]           resp_id,
   output logic [CL_W-1:0]           resp_data_k,
   output logic [CL_W-1:0]           resp_data_l,
   output logic [CNT_W-1:0]          outstanding,
   output logic                      err_orphan
);

   arb_state_t        state;
   arb_state_t        state_next;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   grant_id;
   logic              found;
   logic              grant;
   logic              almostfull_q;
   logic              stall;
   logic [ADDR_W-1:0] addr_k_q;
   logic [ADDR_W-1:0] addr_l_q;
   logic              parity;
   logic [CL_W-1:0]   k_hold;
   logic              tag_full;
   logic              tag_empty;
   logic [ID_W-1:0]   tag_head;
   logic              beat_ok;
   logic              l_pop;

   assign stall   = spl_tx_rd_almostfull || almostfull_q;
   // Beats with no pair in flight are orphans and are dropped entirely.
   assign beat_ok = io_rx_rd_valid && !tag_empty;
   assign l_pop   = beat_ok && parity;

   tag_fifo #(
      .WIDTH (ID_W),
      .DEPTH (MAX_OUTST)
   ) u_tag_fifo (
      .clk   (CLK_400M),
      .rst   (reset),
      .push  (grant),
      .din   (grant_id),
      .pop   (l_pop),
      .dout  (tag_head),
      .full  (tag_full),
      .empty (tag_empty),
      .count (outstanding)
   );

   // Registered copy of almostfull so the stall covers the channel's reaction lag.
   always_ff @(posedge CLK_400M or posedge reset) begin
      if (reset) almostfull_q <= 1'b0;
      else       almostfull_q <= spl_tx_rd_almostfull;
   end

   // Round-robin search: first valid requester at or above rr_ptr, wrapping.
   always_comb begin
      int idx;
      found    = 1'b0;
      grant_id = '0;
      idx      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            found    = 1'b1;
            grant_id = ID_W'(idx);
         end
      end
   end

   // FSM state register.
   always_ff @(posedge CLK_400M or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // FSM next state: grant, then issue k, then issue l, each waiting out stalls.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (grant)  state_next = ST_ISSUE_K;
         ST_ISSUE_K: if (!stall) state_next = ST_ISSUE_L;
         ST_ISSUE_L: if (!stall) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // FSM outputs: one-hot accept pulse; a same-cycle l-beat pop lifts tag_full.
   always_comb begin
      grant     = 1'b0;
      req_ready = '0;
      if (state == ST_IDLE && found && !stall && (!tag_full || l_pop) && !reset) begin
         grant               = 1'b1;
         req_ready[grant_id] = 1'b1;
      end
   end

   // Latch the granted pair, advance rr_ptr, and drive the registered TX strobe.
   always_ff @(posedge CLK_400M or posedge reset) begin
      if (reset) begin
         rr_ptr          <= '0;
         addr_k_q        <= '0;
         addr_l_q        <= '0;
         cor_tx_rd_valid <= 1'b0;
         cor_tx_rd_addr  <= '0;
      end else begin
         cor_tx_rd_valid <= 1'b0;
         if (grant) begin
            rr_ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            addr_k_q <= req_addr_k[grant_id*ADDR_W +: ADDR_W];
            addr_l_q <= req_addr_l[grant_id*ADDR_W +: ADDR_W];
         end
         if (state == ST_ISSUE_K && !stall) begin
            cor_tx_rd_valid <= 1'b1;
            cor_tx_rd_addr  <= addr_k_q;
         end
         if (state == ST_ISSUE_L && !stall) begin
            cor_tx_rd_valid <= 1'b1;
            cor_tx_rd_addr  <= addr_l_q;
         end
      end
   end

   // Join k/l beats into one tagged response; flag beats that have no owner.
   always_ff @(posedge CLK_400M or posedge reset) begin
      if (reset) begin
         parity      <= 1'b0;
         k_hold      <= '0;
         resp_valid  <= 1'b0;
         resp_id     <= '0;
         resp_data_k <= '0;
         resp_data_l <= '0;
         err_orphan  <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         if (io_rx_rd_valid && tag_empty) err_orphan <= 1'b1;
         if (beat_ok) begin
            parity <= ~parity;
            if (!parity) begin
               k_hold <= io_rx_data;
            end else begin
               resp_valid  <= 1'b1;
               resp_id     <= tag_head;
               resp_data_k <= k_hold;
               resp_data_l <= io_rx_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_dram_pair_arbiter.sv
// Directed table-driven bench for dram_pair_arbiter plus multi-cycle corner sequences.
module tb_dram_pair_arbiter;
   import afu_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int CNT_W   = 4;
   localparam int NV      = 22;

   logic                      clk;
   logic                      reset;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr_k;
   logic [NUM_REQ*ADDR_W-1:0] req_addr_l;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      spl_tx_rd_almostfull;
   logic                      cor_tx_rd_valid;
   logic [ADDR_W-1:0]         cor_tx_rd_addr;
   logic                      io_rx_rd_valid;
   logic [CL_W-1:0]           io_rx_data;
   logic                      resp_valid;
   logic [ID_W-1:0]           resp_id;
   logic [CL_W-1:0]           resp_data_k;
   logic [CL_W-1:0]           resp_data_l;
   logic [CNT_W-1:0]          outstanding;
   logic                      err_orphan;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0]  rv;
      logic        rxv;
      logic [15:0] rxd;
      logic [3:0]  ready;
      logic        txv;
      logic [57:0] txa;
      logic        rsp;
      logic [1:0]  rid;
      logic [15:0] rk;
      logic [15:0] rl;
      logic [3:0]  outs;
      logic        err;
   } vec_t;

   vec_t        vt [NV];
   logic [57:0] k_tab [4];
   logic [57:0] l_tab [4];

   dram_pair_arbiter #(
      .NUM_REQ   (4),
      .ID_W      (2),
      .MAX_OUTST (8)
   ) dut (
      .CLK_400M             (clk),
      .reset                (reset),
      .req_valid            (req_valid),
      .req_addr_k           (req_addr_k),
      .req_addr_l           (req_addr_l),
      .req_ready            (req_ready),
      .spl_tx_rd_almostfull (spl_tx_rd_almostfull),
      .cor_tx_rd_valid      (cor_tx_rd_valid),
      .cor_tx_rd_addr       (cor_tx_rd_addr),
      .io_rx_rd_valid       (io_rx_rd_valid),
      .io_rx_data           (io_rx_data),
      .resp_valid           (resp_valid),
      .resp_id              (resp_id),
      .resp_data_k          (resp_data_k),
      .resp_data_l          (resp_data_l),
      .outstanding          (outstanding),
      .err_orphan           (err_orphan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic int oh_idx(input logic [3:0] v);
      int r;
      int n;
      r = -1;
      n = 0;
      for (int b = 0; b < 4; b++) begin
         if (v[b]) begin
            r = b;
            n++;
         end
      end
      if (n != 1) r = -1;
      return r;
   endfunction

   task automatic do_reset(input bit check_zero);
      reset                = 1'b1;
      req_valid            = '0;
      spl_tx_rd_almostfull = 1'b0;
      io_rx_rd_valid       = 1'b0;
      io_rx_data           = '0;
      repeat (3) @(negedge clk);
      if (check_zero) begin
         chk("reset req_ready", req_ready, 0);
         chk("reset tx_valid", cor_tx_rd_valid, 0);
         chk("reset tx_addr", cor_tx_rd_addr, 0);
         chk("reset resp_valid", resp_valid, 0);
         chk("reset resp_data", {resp_id, resp_data_k, resp_data_l}, 0);
         chk("reset outstanding", outstanding, 0);
         chk("reset err_orphan", err_orphan, 0);
      end
      reset = 1'b0;
   endtask

   task automatic run_table();
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         req_valid      = vt[i].rv;
         io_rx_rd_valid = vt[i].rxv;
         io_rx_data     = {32{vt[i].rxd}};
         #1;
         $display("vec %0d: ready=%b txv=%b txa=%0h rsp=%b id=%0d outs=%0d err=%b",
                  i, req_ready, cor_tx_rd_valid, cor_tx_rd_addr, resp_valid, resp_id, outstanding, err_orphan);
         chk($sformatf("v%0d ready", i), req_ready, vt[i].ready);
         chk($sformatf("v%0d tx_valid", i), cor_tx_rd_valid, vt[i].txv);
         if (vt[i].txv) chk($sformatf("v%0d tx_addr", i), cor_tx_rd_addr, vt[i].txa);
         chk($sformatf("v%0d resp_valid", i), resp_valid, vt[i].rsp);
         if (vt[i].rsp) begin
            chk($sformatf("v%0d resp_id", i), resp_id, vt[i].rid);
            chk($sformatf("v%0d resp_k", i), resp_data_k, {32{vt[i].rk}});
            chk($sformatf("v%0d resp_l", i), resp_data_l, {32{vt[i].rl}});
         end
         chk($sformatf("v%0d outstanding", i), outstanding, vt[i].outs);
         chk($sformatf("v%0d err_orphan", i), err_orphan, vt[i].err);
      end
      @(negedge clk);
      req_valid      = '0;
      io_rx_rd_valid = 1'b0;
   endtask

   // All four requesters held: grants rotate 0,1,2,3,0 and responses carry the same IDs.
   task automatic seq_rr();
      int cnt;
      int cyc;
      int got;
      int exp_o [5];
      exp_o = '{0, 1, 2, 3, 0};
      do_reset(1'b0);
      cnt = 0;
      cyc = 0;
      while (cnt < 5 && cyc < 60) begin
         @(negedge clk);
         req_valid = 4'hF;
         #1;
         if (req_ready != '0) begin
            $display("rr grant %0d: ready=%b", cnt, req_ready);
            chk($sformatf("rr grant %0d", cnt), oh_idx(req_ready), exp_o[cnt]);
            cnt++;
         end
         cyc++;
      end
      chk("rr grant count", cnt, 5);
      @(negedge clk);
      req_valid = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rr outstanding", outstanding, 5);
      got = 0;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         io_rx_rd_valid = (c < 10);
         io_rx_data     = {32{16'(c + 1)}};
         #1;
         if (resp_valid) begin
            $display("rr resp %0d: id=%0d", got, resp_id);
            if (got < 5) begin
               chk($sformatf("rr resp_id %0d", got), resp_id, exp_o[got]);
               chk($sformatf("rr resp_k %0d", got), resp_data_k, {32{16'(2 * got + 1)}});
               chk($sformatf("rr resp_l %0d", got), resp_data_l, {32{16'(2 * got + 2)}});
            end
            got++;
         end
      end
      io_rx_rd_valid = 1'b0;
      chk("rr resp count", got, 5);
      chk("rr outstanding drained", outstanding, 0);
   endtask

   // almostfull high for 5 cycles while in ISSUE_L, then a stalled IDLE with a waiting requester.
   task automatic seq_stall();
      logic       exp_txv;
      logic [3:0] exp_rdy;
      do_reset(1'b0);
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         req_valid = (c == 0) ? 4'b0001 : (c >= 9) ? 4'b0100 : 4'b0000;
         spl_tx_rd_almostfull = (c >= 2 && c <= 6) || c == 9 || c == 10;
         #1;
         exp_txv = (c == 2) || (c == 9);
         exp_rdy = (c == 0) ? 4'b0001 : (c == 12) ? 4'b0100 : 4'b0000;
         $display("stall cyc %0d: af=%b txv=%b txa=%0h ready=%b",
                  c, spl_tx_rd_almostfull, cor_tx_rd_valid, cor_tx_rd_addr, req_ready);
         chk($sformatf("stall c%0d tx_valid", c), cor_tx_rd_valid, exp_txv);
         if (c == 2) chk("stall k addr", cor_tx_rd_addr, 58'h010);
         if (c == 9) chk("stall l addr", cor_tx_rd_addr, 58'h011);
         chk($sformatf("stall c%0d ready", c), req_ready, exp_rdy);
      end
      @(negedge clk);
      req_valid            = '0;
      spl_tx_rd_almostfull = 1'b0;
   endtask

   // Fill the tag FIFO, then show a grant can ride on the same cycle as an l-beat pop.
   task automatic seq_full();
      int cnt;
      int cyc;
      do_reset(1'b0);
      cnt = 0;
      cyc = 0;
      while (cnt < 8 && cyc < 80) begin
         @(negedge clk);
         req_valid = 4'b0001;
         #1;
         if (req_ready[0]) cnt++;
         cyc++;
      end
      chk("full grant count", cnt, 8);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("full ready hold %0d", c), req_ready, 0);
      end
      $display("full: outstanding=%0d ready=%b", outstanding, req_ready);
      chk("full outstanding", outstanding, 8);
      @(negedge clk);
      io_rx_rd_valid = 1'b1;
      io_rx_data     = {32{16'h5A5A}};
      #1;
      chk("full ready on k beat", req_ready, 0);
      @(negedge clk);
      io_rx_data = {32{16'h6B6B}};
      #1;
      $display("full l beat: ready=%b", req_ready);
      chk("full ready on pop", req_ready, 4'b0001);
      @(negedge clk);
      io_rx_rd_valid = 1'b0;
      req_valid      = '0;
      #1;
      chk("full outstanding after swap", outstanding, 8);
      chk("full resp_valid", resp_valid, 1);
      chk("full resp_id", resp_id, 0);
      chk("full resp_k", resp_data_k, {32{16'h5A5A}});
      chk("full resp_l", resp_data_l, {32{16'h6B6B}});
   endtask

   // Reset between the k and l beats, then a clean round trip.
   task automatic seq_reset_mid();
      do_reset(1'b0);
      @(negedge clk);
      req_valid = 4'b0100;
      #1;
      chk("rst first grant", req_ready, 4'b0100);
      @(negedge clk);
      req_valid = '0;
      repeat (3) @(negedge clk);
      io_rx_rd_valid = 1'b1;
      io_rx_data     = {32{16'h1111}};
      @(negedge clk);
      io_rx_rd_valid = 1'b0;
      #2;
      reset     = 1'b1;
      req_valid = 4'b0100;
      #1;
      $display("mid reset: outs=%0d ready=%b txv=%b rsp=%b err=%b",
               outstanding, req_ready, cor_tx_rd_valid, resp_valid, err_orphan);
      chk("rst outstanding", outstanding, 0);
      chk("rst ready", req_ready, 0);
      chk("rst tx_valid", cor_tx_rd_valid, 0);
      chk("rst resp_valid", resp_valid, 0);
      chk("rst err_orphan", err_orphan, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst regrant", req_ready, 4'b0100);
      @(negedge clk);
      req_valid = '0;
      repeat (3) @(negedge clk);
      io_rx_rd_valid = 1'b1;
      io_rx_data     = {32{16'h2222}};
      @(negedge clk);
      io_rx_data = {32{16'h3333}};
      @(negedge clk);
      io_rx_rd_valid = 1'b0;
      #1;
      $display("post reset resp: rsp=%b id=%0d", resp_valid, resp_id);
      chk("rst resp_valid", resp_valid, 1);
      chk("rst resp_id", resp_id, 2);
      chk("rst resp_k", resp_data_k, {32{16'h2222}});
      chk("rst resp_l", resp_data_l, {32{16'h3333}});
   endtask

   initial begin
      k_tab = '{58'h010, 58'h100, 58'h020, 58'h030};
      l_tab = '{58'h011, 58'h200, 58'h021, 58'h031};
      for (int i = 0; i < NUM_REQ; i++) begin
         req_addr_k[ADDR_W*i +: ADDR_W] = k_tab[i];
         req_addr_l[ADDR_W*i +: ADDR_W] = l_tab[i];
      end

      //        rv       rxv  rxd       ready    txv  txa      rsp  rid   rk        rl        outs  err
      vt[0]  = '{4'b0000, 1'b1, 16'hEEEE, 4'b0000, 1'b0, 58'h0,   1'b0, 2'd0, 16'h0,    16'h0,    4'd0, 1'b0};
      vt[1]  = '{4'b0010, 1'b0, 16'h0,    4'b0010, 1'b0, 58'h0,   1'b0, 2'd0, 16'h0,    16'h0,    4'd0, 1'b1};
      vt[2]  = '{4'b0000, 1'b0, 16'h0,    4'b0000, 1'b0, 58'h0,   1'b0, 2'd0, 16'h0,    16'h0,    4'd1, 1'b1};
      vt[3]  = '{4'b0000, 1'b0, 16'h0,    4'b0000, 1'b1, 58'h100, 1'b0, 2'd0, 16'h0,    16'h0,    4'd1, 1'b1};
      vt[4]  = '{4'b0000, 1'b0, 16'h0,    4'b0000, 1'b1, 58'h200, 1'b0, 2'd0, 16'h0,    16'h0,    4'd1, 1'b1};
      vt[5]  = '{4'b0000, 1'b1, 16'hAAAA, 4'b0000, 1'b0, 58'h0,   1'b0, 2'd0, 16'h0,    16'h0,    4'd1, 1'b1};
      vt[6]  = '{4'b0000, 1'b1, 16'hBBBB, 4'b0000, 1'b0, 58'h0,   1'b0, 2'd0, 16'h0,    16'h0,    4'd1, 1'b1};
      vt[7]  = '{4'b0000, 1'b0, 16'h0,    4'b0000, 1'b0, 58'h0,   1'b1, 2'd1, 16'hAAAA, 16'hBBBB, 4'd0, 1'b1};
      vt[8]  = '{4'b0000, 1'b0, 16'h0,    4'b0000, 1'b0, 58'h0,   1'b0, 2'd0, 16'h0,    16'h0,    4'd0, 1'b1};
      vt[9]  = '{4'b1001, 1'b0, 16'h0,    4'b1000, 1'b0, 58'h0,   1'b0, 2'd0, 16'h0,    16'h0,    4'd0, 1'b1};
      vt[10] = '{4'b0001, 1'b0, 16'h0,    4'b0000, 1'b0, 58'h0,   1'b0, 2'd0, 16'h0,    16'h0,    4'd1, 1'b1};
      vt[11] = '{4'b0001, 1'b0, 16'h0,    4'b0000, 1'b1, 58'h030, 1'b0, 2'd0, 16'h0,    16'h0,    4'd1, 1'b1};
      vt[12] = '{4'b0001, 1'b0, 16'h0,    4'b0001, 1'b1, 58'h031, 1'b0, 2'd0, 16'h0,    16'h0,    4'd1, 1'b1};
      vt[13] = '{4'b0000, 1'b0, 16'h0,    4'b0000, 1'b0, 58'h0,   1'b0, 2'd0, 16'h0,    16'h0,    4'd2, 1'b1};
      vt[14] = '{4'b0000, 1'b0, 16'h0,    4'b0000, 1'b1, 58'h010, 1'b0, 2'd0, 16'h0,    16'h0,    4'd2, 1'b1};
      vt[15] = '{4'b0000, 1'b0, 16'h0,    4'b0000, 1'b1, 58'h011, 1'b0, 2'd0, 16'h0,    16'h0,    4'd2, 1'b1};
      vt[16] = '{4'b0000, 1'b1, 16'hC0C0, 4'b0000, 1'b0, 58'h0,   1'b0, 2'd0, 16'h0,    16'h0,    4'd2, 1'b1};
      vt[17] = '{4'b0000, 1'b1, 16'hD0D0, 4'b0000, 1'b0, 58'h0,   1'b0, 2'd0, 16'h0,    16'h0,    4'd2, 1'b1};
      vt[18] = '{4'b0000, 1'b1, 16'hE0E0, 4'b0000, 1'b0, 58'h0,   1'b1, 2'd3, 16'hC0C0, 16'hD0D0, 4'd1, 1'b1};
      vt[19] = '{4'b0000, 1'b1, 16'hF0F0, 4'b0000, 1'b0, 58'h0,   1'b0, 2'd0, 16'h0,    16'h0,    4'd1, 1'b1};
      vt[20] = '{4'b0000, 1'b0, 16'h0,    4'b0000, 1'b0, 58'h0,   1'b1, 2'd0, 16'hE0E0, 16'hF0F0, 4'd0, 1'b1};
      vt[21] = '{4'b0000, 1'b0, 16'h0,    4'b0000, 1'b0, 58'h0,   1'b0, 2'd0, 16'h0,    16'h0,    4'd0, 1'b1};

      do_reset(1'b1);
      run_table();
      seq_rr();
      seq_stall();
      seq_full();
      seq_reset_mid();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
